bus_transfer_sequencer: RTL and testbench
=========================================

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 The block SHALL take one clock and one reset: the clock is rising-edge; the reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, which sets the number of cycles the source drives the bus before the load strobe (legal range 1..15).
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock.
- clear  input  1  asynchronous active-low reset.
- req_valid  input  1  transfer request present.
- req_src  input  5  source code.
- req_dst  input  5  destination code.
- req_ready  output  1  sequencer can accept a request.
- src_out_en  output  32  one-hot source out-enables, indexed by code, feeding the bus encoder.
- dst_in_en  output  32  one-hot destination load enables, indexed by code.
- busy  output  1  transfer in progress.
- xfer_done  output  1  one-cycle pulse when a transfer completes.
- xfer_err  output  1  one-cycle pulse when a request is illegal.
- xfer_count  output  8  count of completed legal transfers, saturating.

Function
REQ-004 The code map SHALL be: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C, 24 Y, 25 MAR, 26 IR, 27 OutPort, 28-31 unused.
REQ-005 Legal source codes SHALL be 0-24; codes 25-31 are illegal sources.
REQ-006 Legal destination codes SHALL be 0-17, 20, 21 and 24-27; codes 18, 19, 22, 23 and 28-31 are illegal destinations.
REQ-007 The state machine SHALL have the states IDLE, DRIVE, LOAD, DONE and ERR.
REQ-008 req_ready SHALL be 1 only in IDLE.
REQ-009 A request is accepted on a rising edge with req_valid=1 and req_ready=1; at that edge req_src and req_dst are captured into internal registers.
REQ-010 Once a request is accepted, later changes on the req_* inputs SHALL have no effect until the next acceptance.
REQ-011 On acceptance, if either the source or the destination code is illegal, the next state SHALL be ERR; otherwise it SHALL be DRIVE, with the settle counter loaded to SETTLE_CYCLES.
REQ-012 In DRIVE, src_out_en[src] SHALL be 1, every other bit 0, and dst_in_en SHALL be all 0; the counter decrements each cycle and the state moves to LOAD after exactly SETTLE_CYCLES cycles.
REQ-013 LOAD SHALL last exactly one cycle, with src_out_en[src]=1 and dst_in_en[dst]=1 both held; the next state is DONE.
REQ-014 DONE SHALL last one cycle with xfer_done=1 and all enables 0; xfer_count increments, saturating at 255; the next state is IDLE.
REQ-015 ERR SHALL last one cycle with xfer_err=1 and all enables 0; xfer_count is unchanged; the next state is IDLE.
REQ-016 Total latency from the accept edge to xfer_done high SHALL be SETTLE_CYCLES+2 cycles.
REQ-017 A request with src equal to dst and both legal (for example R5 to R5) SHALL be treated as a legal transfer and executed normally.
REQ-018 busy SHALL be 1 in DRIVE, LOAD, DONE and ERR.
REQ-019 src_out_en SHALL never have more than one bit set, and dst_in_en SHALL never have more than one bit set.
REQ-020 No enable bit SHALL ever be set outside the legal code sets of REQ-005 and REQ-006.
REQ-021 All outputs SHALL be driven from registers or decoded from the registered state only, with no combinational path from the req_* inputs to any enable.
REQ-022 Back-to-back requests SHALL be supported: a request held at req_valid=1 while in DONE or ERR is accepted on the first IDLE cycle that follows.

Reset
REQ-023 While clear=0, the state SHALL be IDLE, src_out_en=0, dst_in_en=0, busy=0, xfer_done=0, xfer_err=0, xfer_count=0, the captured codes=0, the settle counter=0 and req_ready=1.
REQ-024 Reset asserted mid-transfer, including during LOAD, SHALL clear all enables immediately and asynchronously; the aborted transfer is neither retried nor counted.
REQ-025 After clear deasserts, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-026 The 5-bit code constants (R0..OutPort), the legal-source mask and the legal-destination mask SHALL live in the shared bus-definitions package used by the bus encoder and multiplexer.
REQ-027 One sub-module SHALL be used: decoder_5_to_32, a combinational 5-bit to one-hot decoder with an enable input, instantiated twice (source and destination).
REQ-028 The state machine, settle counter and transfer counter SHALL reside in the top module.

Verification
REQ-029 With SETTLE_CYCLES=1, a request src=20 (PC), dst=25 (MAR) accepted at cycle 0 -> src_out_en=0x00100000 in cycles 1-2; dst_in_en=0x02000000 in cycle 2 only; xfer_done=1 in cycle 3; xfer_count=1.
REQ-030 A request src=5, dst=22 (InPort) -> xfer_err=1 one cycle after acceptance; no enable ever set; xfer_count unchanged.
REQ-031 A request src=27, dst=3 -> xfer_err=1; all enables remain 0.
REQ-032 With SETTLE_CYCLES=3, a request src=24 (Y), dst=0 -> src_out_en bit 24 high for 4 cycles; dst_in_en bit 0 high only in the 4th; xfer_done 5 cycles after acceptance.
REQ-033 clear=0 pulsed during LOAD of src=1, dst=2 -> enables are 0 within the same cycle; req_ready=1; xfer_count unchanged.
REQ-034 300 back-to-back legal requests with req_valid held at 1 -> accepted every SETTLE_CYCLES+3 cycles; xfer_count saturates at 255; the one-hot property holds on every cycle.

Source files
------------

// File: rtl/bus_transfer_sequencer_pkg.sv
// rtl/bus_transfer_sequencer_pkg.sv - shared bus code map, legality masks and sequencer states
package bus_transfer_sequencer_pkg;

  // 5-bit bus codes; R0..R15 occupy codes 0..15
  localparam logic [4:0] CODE_R0      = 5'd0;
  localparam logic [4:0] CODE_R15     = 5'd15;
  localparam logic [4:0] CODE_HI      = 5'd16;
  localparam logic [4:0] CODE_LO      = 5'd17;
  localparam logic [4:0] CODE_ZHI     = 5'd18;
  localparam logic [4:0] CODE_ZLO     = 5'd19;
  localparam logic [4:0] CODE_PC      = 5'd20;
  localparam logic [4:0] CODE_MDR     = 5'd21;
  localparam logic [4:0] CODE_INPORT  = 5'd22;
  localparam logic [4:0] CODE_C       = 5'd23;
  localparam logic [4:0] CODE_Y       = 5'd24;
  localparam logic [4:0] CODE_MAR     = 5'd25;
  localparam logic [4:0] CODE_IR      = 5'd26;
  localparam logic [4:0] CODE_OUTPORT = 5'd27;

  // Sources: codes 0..24 may drive the bus
  localparam logic [31:0] LEGAL_SRC_MASK = 32'h01FF_FFFF;
  // Destinations: 0..17, PC, MDR, Y, MAR, IR, OutPort may be loaded
  localparam logic [31:0] LEGAL_DST_MASK = 32'h0F33_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LOAD  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } seqState_t;

  function automatic logic isLegalSrc(input logic [4:0] code);
    return LEGAL_SRC_MASK[code];
  endfunction

  function automatic logic isLegalDst(input logic [4:0] code);
    return LEGAL_DST_MASK[code];
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_decoder.sv
// rtl/bus_transfer_sequencer_decoder.sv - 5-to-32 one-hot decoder with enable
module decoder_5_to_32 (
  input  logic [4:0]  code,
  input  logic        enable,
  output logic [31:0] oneHot
);

  // Exactly one bit set when enabled, all zero otherwise
  always_comb begin
    oneHot = '0;
    if (enable) oneHot[code] = 1'b1;
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - sequences one bus register transfer per request
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req_valid,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic        req_ready,
  output logic [31:0] src_out_en,
  output logic [31:0] dst_in_en,
  output logic        busy,
  output logic        xfer_done,
  output logic        xfer_err,
  output logic [7:0]  xfer_count
);

  seqState_t   state;
  seqState_t   nextState;
  logic [4:0]  srcCode;
  logic [4:0]  dstCode;
  logic [3:0]  settleCnt;
  logic        accept;
  logic        reqLegal;
  logic        srcActive;
  logic        dstActive;

  assign accept   = (state == IDLE) && req_valid;
  assign reqLegal = isLegalSrc(req_src) && isLegalDst(req_dst);

  // Enables decode only from registered state and captured codes, so reset
  // clearing the state register drops them asynchronously
  assign srcActive = (state == DRIVE) || (state == LOAD);
  assign dstActive = (state == LOAD);

  decoder_5_to_32 srcDecoder (
    .code   (srcCode),
    .enable (srcActive),
    .oneHot (src_out_en)
  );

  decoder_5_to_32 dstDecoder (
    .code   (dstCode),
    .enable (dstActive),
    .oneHot (dst_in_en)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign xfer_done = (state == DONE);
  assign xfer_err  = (state == ERR);

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state: legality is judged on the live request only at acceptance
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req_valid) nextState = reqLegal ? DRIVE : ERR;
      DRIVE:   if (settleCnt <= 4'd1) nextState = LOAD;
      LOAD:    nextState = DONE;
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Capture codes at acceptance and run the settle countdown while driving
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      srcCode   <= '0;
      dstCode   <= '0;
      settleCnt <= '0;
    end else if (accept) begin
      srcCode   <= req_src;
      dstCode   <= req_dst;
      settleCnt <= reqLegal ? 4'(SETTLE_CYCLES) : 4'd0;
    end else if (state == DRIVE && settleCnt != 4'd0) begin
      settleCnt <= settleCnt - 4'd1;
    end
  end

  // Completed-transfer counter, saturating at 255
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                                 xfer_count <= '0;
    else if (state == DONE && xfer_count != 8'hFF) xfer_count <= xfer_count + 8'd1;
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - directed self-checking bench for bus_transfer_sequencer
module tb_bus_transfer_sequencer;

  localparam logic [31:0] SRC_MASK = 32'h01FF_FFFF;
  localparam logic [31:0] DST_MASK = 32'h0F33_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic        req_valid;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;

  logic        ready1, busy1, done1, err1;
  logic [31:0] srcEn1, dstEn1;
  logic [7:0]  cnt1;
  logic        ready3, busy3, done3, err3;
  logic [31:0] srcEn3, dstEn3;
  logic [7:0]  cnt3;

  int total = 0;
  int bad = 0;

  bus_transfer_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(ready1), .src_out_en(srcEn1), .dst_in_en(dstEn1), .busy(busy1),
    .xfer_done(done1), .xfer_err(err1), .xfer_count(cnt1)
  );

  bus_transfer_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(ready3), .src_out_en(srcEn3), .dst_in_en(dstEn3), .busy(busy3),
    .xfer_done(done3), .xfer_err(err3), .xfer_count(cnt3)
  );

  task automatic doReset();
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  // Presents a request for one edge, then scrambles the inputs; returns at cycle 1
  task automatic issue(input logic [4:0] s, input logic [4:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_src = s;
    req_dst = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_src = 5'd31;
    req_dst = 5'd30;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear = 1'b0;
    #1;
    total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready1); end
    total++; if (srcEn1 !== 32'h0 || dstEn1 !== 32'h0) begin bad++; $display("FAIL reset_en got=%h/%h want=0/0", srcEn1, dstEn1); end
    total++; if ({busy1, done1, err1} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy1, done1, err1}); end
    total++; if (cnt1 !== 8'd0 || cnt3 !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d want=0/0", cnt1, cnt3); end
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic test_pc_to_mar();
    doReset();
    issue(5'd20, 5'd25);
    total++; if (srcEn1 !== 32'h0010_0000 || dstEn1 !== 32'h0) begin bad++; $display("FAIL pc_mar_c1 got=%h/%h want=00100000/0", srcEn1, dstEn1); end
    total++; if (busy1 !== 1'b1 || ready1 !== 1'b0) begin bad++; $display("FAIL pc_mar_busy got=%b%b want=10", busy1, ready1); end
    @(negedge clk);
    total++; if (srcEn1 !== 32'h0010_0000 || dstEn1 !== 32'h0200_0000) begin bad++; $display("FAIL pc_mar_c2 got=%h/%h want=00100000/02000000", srcEn1, dstEn1); end
    @(negedge clk);
    total++; if (done1 !== 1'b1 || srcEn1 !== 32'h0 || dstEn1 !== 32'h0) begin bad++; $display("FAIL pc_mar_c3 got=%b %h/%h want=1 0/0", done1, srcEn1, dstEn1); end
    @(negedge clk);
    total++; if (done1 !== 1'b0 || cnt1 !== 8'd1 || ready1 !== 1'b1) begin bad++; $display("FAIL pc_mar_c4 got=%b %0d %b want=0 1 1", done1, cnt1, ready1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal(input logic [4:0] s, input logic [4:0] d);
    doReset();
    issue(s, d);
    total++; if (err1 !== 1'b1 || err3 !== 1'b1 || done1 !== 1'b0) begin bad++; $display("FAIL illegal_err src=%0d dst=%0d got=%b%b%b want=110", s, d, err1, err3, done1); end
    total++; if ((srcEn1 | dstEn1 | srcEn3 | dstEn3) !== 32'h0 || busy1 !== 1'b1) begin bad++; $display("FAIL illegal_en src=%0d dst=%0d got=%h busy=%b want=0 1", s, d, srcEn1 | dstEn1 | srcEn3 | dstEn3, busy1); end
    @(negedge clk);
    total++; if (err1 !== 1'b0 || cnt1 !== 8'd0 || ready1 !== 1'b1 || (srcEn1 | dstEn1) !== 32'h0) begin bad++; $display("FAIL illegal_after src=%0d dst=%0d got=%b %0d %b want=0 0 1", s, d, err1, cnt1, ready1); end
  endtask

  task automatic test_settle3();
    logic [31:0] expDst;
    doReset();
    issue(5'd24, 5'd0);
    for (int c = 1; c <= 4; c++) begin
      expDst = (c == 4) ? 32'h1 : 32'h0;
      total++;
      if (srcEn3 !== 32'h0100_0000 || dstEn3 !== expDst || done3 !== 1'b0) begin
        bad++; $display("FAIL settle3_c%0d got=%h/%h done=%b want=01000000/%h 0", c, srcEn3, dstEn3, done3, expDst);
      end
      @(negedge clk);
    end
    total++; if (done3 !== 1'b1 || srcEn3 !== 32'h0 || dstEn3 !== 32'h0) begin bad++; $display("FAIL settle3_done got=%b %h/%h want=1 0/0", done3, srcEn3, dstEn3); end
    @(negedge clk);
    total++; if (cnt3 !== 8'd1 || ready3 !== 1'b1) begin bad++; $display("FAIL settle3_count got=%0d %b want=1 1", cnt3, ready3); end
  endtask

  task automatic test_same_reg();
    doReset();
    issue(5'd5, 5'd5);
    @(negedge clk);
    total++; if (srcEn1 !== 32'h20 || dstEn1 !== 32'h20) begin bad++; $display("FAIL same_reg_load got=%h/%h want=20/20", srcEn1, dstEn1); end
    @(negedge clk);
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL same_reg_done got=%b want=1", done1); end
    @(negedge clk);
    total++; if (cnt1 !== 8'd1) begin bad++; $display("FAIL same_reg_count got=%0d want=1", cnt1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    doReset();
    issue(5'd1, 5'd2);
    @(negedge clk);
    total++; if (srcEn1 !== 32'h2 || dstEn1 !== 32'h4) begin bad++; $display("FAIL mid_load got=%h/%h want=2/4", srcEn1, dstEn1); end
    #2 clear = 1'b0;
    #1;
    total++; if (srcEn1 !== 32'h0 || dstEn1 !== 32'h0 || srcEn3 !== 32'h0) begin bad++; $display("FAIL mid_clear_en got=%h/%h/%h want=0", srcEn1, dstEn1, srcEn3); end
    total++; if (ready1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 8'd0) begin bad++; $display("FAIL mid_clear_state got=%b%b %0d want=10 0", ready1, busy1, cnt1); end
    @(negedge clk);
    clear = 1'b1;
    req_valid = 1'b1;
    req_src = 5'd3;
    req_dst = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (busy1 !== 1'b1 || srcEn1 !== 32'h8) begin bad++; $display("FAIL first_accept got=%b %h want=1 8", busy1, srcEn1); end
    repeat (6) @(negedge clk);
    total++; if (cnt1 !== 8'd1 || cnt3 !== 8'd1) begin bad++; $display("FAIL first_accept_count got=%0d/%0d want=1/1", cnt1, cnt3); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int last1 = -1;
    int last3 = -1;
    int n3 = 0;
    doReset();
    @(negedge clk);
    req_valid = 1'b1;
    req_src = 5'd10;
    req_dst = 5'd21;
    while (n3 < 300 && cyc < 2500) begin
      @(negedge clk);
      cyc++;
      total++;
      if ($countones(srcEn1) > 1 || $countones(dstEn1) > 1 || $countones(srcEn3) > 1 || $countones(dstEn3) > 1 ||
          (srcEn1 & ~SRC_MASK) != 0 || (dstEn1 & ~DST_MASK) != 0 || (srcEn3 & ~SRC_MASK) != 0 || (dstEn3 & ~DST_MASK) != 0) begin
        bad++; $display("FAIL b2b_onehot cyc=%0d got=%h/%h %h/%h want=one-hot legal", cyc, srcEn1, dstEn1, srcEn3, dstEn3);
      end
      if (done1) begin
        if (last1 >= 0) begin
          total++; if (cyc - last1 != 4) begin bad++; $display("FAIL b2b_period1 got=%0d want=4", cyc - last1); end
        end
        last1 = cyc;
      end
      if (done3) begin
        if (last3 >= 0) begin
          total++; if (cyc - last3 != 6) begin bad++; $display("FAIL b2b_period3 got=%0d want=6", cyc - last3); end
        end
        last3 = cyc;
        n3++;
      end
    end
    total++; if (n3 < 300) begin bad++; $display("FAIL b2b_timeout got=%0d want=300", n3); end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (cnt1 !== 8'd255 || cnt3 !== 8'd255) begin bad++; $display("FAIL b2b_saturate got=%0d/%0d want=255/255", cnt1, cnt3); end
  endtask

  initial begin
    clear = 1'b0;
    req_valid = 1'b0;
    req_src = 5'd0;
    req_dst = 5'd0;
    test_reset();
    test_pc_to_mar();
    test_illegal(5'd5, 5'd22);
    test_illegal(5'd27, 5'd3);
    test_settle3();
    test_same_reg();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
